// File: rtl/aes_pkg.sv
// Shared AES byte/column types and GF(2^8) helpers used by the MixColumns datapath.
package aes_pkg;

  typedef logic [7:0]  aes_byte_t;
  typedef logic [31:0] aes_col_t;

  localparam aes_byte_t AES_POLY = 8'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mc_state_e;

  function automatic aes_byte_t xtime(input aes_byte_t x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

  // Only the constants that appear in the (Inv)MixColumns matrices are supported.
  function automatic aes_byte_t gf_mul_const(input aes_byte_t x, input aes_byte_t c);
    aes_byte_t x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (c)
      8'h01:   return x;
      8'h02:   return x2;
      8'h03:   return x2 ^ x;
      8'h09:   return x8 ^ x;
      8'h0B:   return x8 ^ x2 ^ x;
      8'h0D:   return x8 ^ x4 ^ x;
      8'h0E:   return x8 ^ x4 ^ x2;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/gf_mix_column.sv
// Combinational MixColumns / InvMixColumns on one 32-bit column (row 0 in the MSB byte).
module gf_mix_column
  import aes_pkg::*;
(
  input  aes_col_t col,
  input  logic     inv,
  output aes_col_t result
);

  aes_byte_t a    [4];
  aes_byte_t coef [4];
  aes_byte_t r    [4];

  // Each matrix row is the first row rotated right by the row index.
  always_comb begin
    result = '0;
    for (int j = 0; j < 4; j++) begin
      a[2'(j)] = col[31-8*j -: 8];
    end
    if (inv) coef = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
    else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int i = 0; i < 4; i++) begin
      r[2'(i)] = 8'h00;
      for (int j = 0; j < 4; j++) begin
        r[2'(i)] = r[2'(i)] ^ gf_mul_const(a[2'(j)], coef[2'(j - i)]);
      end
    end
    result = {r[0], r[1], r[2], r[3]};
  end

endmodule

// File: rtl/mix_columns_engine.sv
// Iterative MixColumns stage: accepts a full state, transforms COLS_PER_CYCLE columns
// per cycle in place, then presents the result until downstream takes it.
module mix_columns_engine
  import aes_pkg::*;
#(
  parameter  int NB             = 4,
  parameter  int COLS_PER_CYCLE = 1,
  localparam int DATA_W         = 32 * NB
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_inv,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  localparam int            CW       = $clog2(NB);
  localparam logic [CW-1:0] LAST_COL = CW'(NB - COLS_PER_CYCLE);
  localparam logic [CW-1:0] COL_STEP = CW'(COLS_PER_CYCLE);

  if (!(NB == 4 || NB == 6 || NB == 8) || COLS_PER_CYCLE < 1 ||
      (NB % COLS_PER_CYCLE) != 0) begin : g_bad_params
    $error("mix_columns_engine: NB must be 4/6/8 and divisible by COLS_PER_CYCLE");
  end

  mc_state_e         state_q, state_d;
  logic [CW-1:0]     col_q;
  logic              inv_q;
  aes_col_t          st_q     [NB];
  aes_col_t          st_nxt   [NB];
  aes_col_t          in_cols  [NB];
  aes_col_t          grp_in   [COLS_PER_CYCLE];
  aes_col_t          grp_out  [COLS_PER_CYCLE];
  logic [DATA_W-1:0] st_nxt_flat;
  logic [DATA_W-1:0] out_q;
  logic              accept;
  logic              last_grp;

  assign accept   = (state_q == ST_IDLE) && in_valid;
  assign last_grp = (state_q == ST_BUSY) && (col_q == LAST_COL);
  assign out_data = out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_BUSY;
      end
      ST_BUSY: begin
        busy = 1'b1;
        if (col_q == LAST_COL) state_d = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  for (genvar c = 0; c < NB; c++) begin : g_cols
    assign in_cols[c]                       = in_data[DATA_W-1-32*c -: 32];
    assign st_nxt_flat[DATA_W-1-32*c -: 32] = st_nxt[c];
  end

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_lanes
    assign grp_in[g] = st_q[col_q + CW'(g)];
    gf_mix_column u_col (
      .col    (grp_in[g]),
      .inv    (inv_q),
      .result (grp_out[g])
    );
  end

  always_comb begin
    st_nxt = st_q;
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      st_nxt[col_q + CW'(g)] = grp_out[g];
    end
  end

  // out_q is a separate copy so the output only ever shows finished results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      inv_q <= 1'b0;
      out_q <= '0;
      for (int c = 0; c < NB; c++) st_q[c] <= '0;
    end else if (accept) begin
      st_q  <= in_cols;
      col_q <= '0;
      inv_q <= in_inv;
    end else if (state_q == ST_BUSY) begin
      st_q  <= st_nxt;
      col_q <= col_q + COL_STEP;
      if (last_grp) out_q <= st_nxt_flat;
    end
  end

endmodule

// File: tb/tb_mix_columns_engine.sv
// Directed and reference-model checks of mix_columns_engine at three parameter points.
module tb_mix_columns_engine;

  logic         clk;
  logic         rst_n;
  logic         in_valid, in_ready, in_inv, out_valid, out_ready, busy;
  logic [127:0] in_data, out_data;
  logic         v8_in_valid, v8_in_ready, v8_in_inv, v8_out_valid, v8_out_ready, v8_busy;
  logic [255:0] v8_in_data, v8_out_data;
  logic         v6_in_valid, v6_in_ready, v6_in_inv, v6_out_valid, v6_out_ready, v6_busy;
  logic [191:0] v6_in_data, v6_out_data;

  int n_checks = 0;
  int n_err    = 0;

  mix_columns_engine #(.NB(4), .COLS_PER_CYCLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy));

  mix_columns_engine #(.NB(8), .COLS_PER_CYCLE(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8_in_valid), .in_ready(v8_in_ready),
    .in_data(v8_in_data), .in_inv(v8_in_inv), .out_valid(v8_out_valid),
    .out_ready(v8_out_ready), .out_data(v8_out_data), .busy(v8_busy));

  mix_columns_engine #(.NB(6), .COLS_PER_CYCLE(3)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(v6_in_valid), .in_ready(v6_in_ready),
    .in_data(v6_in_data), .in_inv(v6_in_inv), .out_valid(v6_out_valid),
    .out_ready(v6_out_ready), .out_data(v6_out_data), .busy(v6_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] din;
    logic         inv;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Shift-and-add multiply, independent of the constant-only multiplier in the design.
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1B;
      b  = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [255:0] ref_mix(input logic [255:0] d, input int nb, input logic inv);
    logic [255:0] res;
    logic [7:0]   coef [4];
    logic [31:0]  col;
    logic [7:0]   acc;
    res = '0;
    if (inv) coef = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
    else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < nb; c++) begin
      col = d[nb*32-1-32*c -: 32];
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(col[31-8*j -: 8], coef[(j - r + 4) % 4]);
        res[nb*32-1-32*c-8*r -: 8] = acc;
      end
    end
    return res;
  endfunction

  task automatic xfer4(input logic [127:0] d, input logic inv, output logic [127:0] r, output int lat);
    @(negedge clk);
    in_data = d; in_inv = inv; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    r = out_data;
    @(posedge clk); #1;
  endtask

  task automatic xfer8(input logic [255:0] d, input logic inv, output logic [255:0] r, output int lat);
    @(negedge clk);
    v8_in_data = d; v8_in_inv = inv; v8_in_valid = 1'b1; v8_out_ready = 1'b1;
    @(posedge clk); #1;
    v8_in_valid = 1'b0;
    lat = 0;
    while (!v8_out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    r = v8_out_data;
    @(posedge clk); #1;
  endtask

  task automatic xfer6(input logic [191:0] d, input logic inv, output logic [191:0] r, output int lat);
    @(negedge clk);
    v6_in_data = d; v6_in_inv = inv; v6_in_valid = 1'b1; v6_out_ready = 1'b1;
    @(posedge clk); #1;
    v6_in_valid = 1'b0;
    lat = 0;
    while (!v6_out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    r = v6_out_data;
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] r4;
    logic [255:0] d8, r8, b8;
    logic [191:0] d6, r6, b6;
    int           lat;

    vecs[0] = '{128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, 128'h046681e5e0cb199a48f8d37a2806264c};
    vecs[1] = '{128'h046681e5e0cb199a48f8d37a2806264c, 1'b1, 128'hd4bf5d30e0b452aeb84111f11e2798e5};
    vecs[2] = '{{4{32'hdb135345}}, 1'b0, {4{32'h8e4da1bc}}};
    vecs[3] = '{{4{32'hf20a225c}}, 1'b0, {4{32'h9fdc589d}}};
    vecs[4] = '{{4{32'hd4d4d4d5}}, 1'b0, {4{32'hd5d5d7d6}}};
    vecs[5] = '{{4{32'h2d26314c}}, 1'b0, {4{32'h4d7ebdf8}}};
    vecs[6] = '{{4{32'hc6c6c6c6}}, 1'b0, {4{32'hc6c6c6c6}}};
    vecs[7] = '{{4{32'h01010101}}, 1'b0, {4{32'h01010101}}};

    rst_n = 1'b0;
    in_valid = 1'b0; in_inv = 1'b0; in_data = '0; out_ready = 1'b1;
    v8_in_valid = 1'b0; v8_in_inv = 1'b0; v8_in_data = '0; v8_out_ready = 1'b1;
    v6_in_valid = 1'b0; v6_in_inv = 1'b0; v6_in_data = '0; v6_out_ready = 1'b1;
    #3;
    chk("reset_out_valid", 256'(out_valid), 256'd0);
    chk("reset_out_data", 256'(out_data), 256'd0);
    chk("reset_busy", 256'(busy), 256'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", 256'(in_ready), 256'd1);

    for (int i = 0; i < 8; i++) begin
      xfer4(vecs[i].din, vecs[i].inv, r4, lat);
      chk($sformatf("vec%0d_data", i), 256'(r4), 256'(vecs[i].exp));
      chk($sformatf("vec%0d_latency", i), 256'(lat), 256'd4);
    end

    // Backpressure: hold the result for 10 cycles while poking the input side.
    @(negedge clk);
    in_data = vecs[0].din; in_inv = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("bp_latency", 256'(lat), 256'd4);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_inv = 1'b1; in_data = ~vecs[0].din;
      @(posedge clk); #1;
      chk($sformatf("bp_valid_%0d", i), 256'(out_valid), 256'd1);
      chk($sformatf("bp_data_%0d", i), 256'(out_data), 256'(vecs[0].exp));
      chk($sformatf("bp_in_ready_%0d", i), 256'(in_ready), 256'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", 256'(in_ready), 256'd1);
    chk("bp_release_out_valid", 256'(out_valid), 256'd0);
    chk("bp_release_busy", 256'(busy), 256'd0);
    chk("bp_release_data_held", 256'(out_data), 256'(vecs[0].exp));

    // Asynchronous reset two cycles into BUSY.
    @(negedge clk);
    in_data = vecs[2].din; in_inv = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("abort_busy_before", 256'(busy), 256'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 256'(out_valid), 256'd0);
    chk("abort_out_data", 256'(out_data), 256'd0);
    chk("abort_busy", 256'(busy), 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    xfer4(vecs[0].din, 1'b0, r4, lat);
    chk("after_abort_data", 256'(r4), 256'(vecs[0].exp));
    chk("after_abort_latency", 256'(lat), 256'd4);

    // Parameter points against the reference model, forward then inverse.
    for (int k = 0; k < 3; k++) begin
      for (int w = 0; w < 8; w++) d8[255-32*w -: 32] = $urandom;
      xfer8(d8, 1'b0, r8, lat);
      chk($sformatf("nb8_fwd_%0d", k), r8, ref_mix(d8, 8, 1'b0));
      chk($sformatf("nb8_latency_%0d", k), 256'(lat), 256'd4);
      xfer8(r8, 1'b1, b8, lat);
      chk($sformatf("nb8_roundtrip_%0d", k), b8, d8);

      for (int w = 0; w < 6; w++) d6[191-32*w -: 32] = $urandom;
      xfer6(d6, 1'b0, r6, lat);
      chk($sformatf("nb6_fwd_%0d", k), 256'(r6), ref_mix(256'(d6), 6, 1'b0));
      chk($sformatf("nb6_latency_%0d", k), 256'(lat), 256'd2);
      xfer6(r6, 1'b1, b6, lat);
      chk($sformatf("nb6_roundtrip_%0d", k), 256'(b6), 256'(d6));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
